// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, widths and helpers for the Sobel controller
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACCUM,
        MAG,
        OUT
    } ctrl_state_t;

    localparam int ACC_W  = 13;
    localparam int PIX_W  = 4;
    localparam int COEF_W = 5;
    localparam int OUT_W  = 8;

    function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
        return v[ACC_W-1] ? ACC_W'(-v) : ACC_W'(v);
    endfunction

endpackage

// File: rtl/sobel_conv_ctrl_if.sv
// rtl/sobel_conv_ctrl_if.sv - window, select-block and output-pixel signals of the Sobel controller
interface sobel_conv_ctrl_if;
    import sobel_pkg::*;

    logic                     win_valid;
    logic                     win_ready;
    logic                     busy;
    logic                     calc_enable;
    logic signed [COEF_W-1:0] x_a;
    logic signed [COEF_W-1:0] x_b;
    logic                     x_done;
    logic signed [COEF_W-1:0] y_a;
    logic signed [COEF_W-1:0] y_b;
    logic                     y_done;
    logic [OUT_W-1:0]         pix_out;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     err;

    modport slave (
        input  win_valid, x_a, x_b, x_done, y_a, y_b, y_done, pix_ready,
        output win_ready, busy, calc_enable, pix_out, pix_valid, err
    );

    modport master (
        output win_valid, x_a, x_b, x_done, y_a, y_b, y_done, pix_ready,
        input  win_ready, busy, calc_enable, pix_out, pix_valid, err
    );

endinterface

// File: rtl/sobel_mac.sv
// rtl/sobel_mac.sv - signed 5x5 multiply feeding a 13-bit accumulator with clear and enable
module sobel_mac
    import sobel_pkg::*;
(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [2*COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W-2*COEF_W){prod[2*COEF_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/sobel_conv_ctrl.sv
// rtl/sobel_conv_ctrl.sv - Sobel pass sequencer and |Gx|+|Gy| output stage
// EDGE_THRESH_EN: when defined, pix_out becomes a binary edge map against THRESH.
module sobel_conv_ctrl
    import sobel_pkg::*;
#(
    parameter int          SHIFT   = 2,
    parameter int          TIMEOUT = 15,
    parameter logic [7:0]  THRESH  = 8'd64
) (
    input  logic               clk,
    input  logic               n_rst,
    sobel_conv_ctrl_if.slave   bus
);

    ctrl_state_t state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        x_seen_q, x_seen_d;
    logic        y_seen_q, y_seen_d;
    logic [OUT_W-1:0] pix_q, pix_d;

    logic acc_clr, acc_en;
    logic win_ready, busy, calc_enable, pix_valid, err;
    logic signed [ACC_W-1:0] acc_x, acc_y;
    logic [ACC_W-1:0] mag_sum, mag;
    logic [OUT_W-1:0] mag_sat, pix_val;

    sobel_mac u_mac_x (
        .clk(clk), .n_rst(n_rst), .clr(acc_clr), .en(acc_en),
        .a(bus.x_a), .b(bus.x_b), .acc(acc_x)
    );

    sobel_mac u_mac_y (
        .clk(clk), .n_rst(n_rst), .clr(acc_clr), .en(acc_en),
        .a(bus.y_a), .b(bus.y_b), .acc(acc_y)
    );

    // Both magnitudes are bounded by 1440, so the 13-bit sum cannot wrap.
    assign mag_sum = abs_acc(acc_x) + abs_acc(acc_y);
    assign mag     = mag_sum >> SHIFT;
    assign mag_sat = (mag > ACC_W'(255)) ? 8'hFF : mag[OUT_W-1:0];

`ifdef EDGE_THRESH_EN
    assign pix_val = (mag_sat >= THRESH) ? 8'hFF : 8'h00;
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign pix_val       = mag_sat;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        x_seen_d    = x_seen_q;
        y_seen_d    = y_seen_q;
        pix_d       = pix_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        win_ready   = 1'b0;
        busy        = 1'b0;
        calc_enable = 1'b0;
        pix_valid   = 1'b0;
        err         = 1'b0;
        case (state_q)
            IDLE: begin
                win_ready = 1'b1;
                if (bus.win_valid) begin
                    state_d  = START;
                    acc_clr  = 1'b1;
                    timer_d  = '0;
                    x_seen_d = 1'b0;
                    y_seen_d = 1'b0;
                end
            end
            START: begin
                calc_enable = 1'b1;
                busy        = 1'b1;
                state_d     = ACCUM;
            end
            ACCUM: begin
                busy     = 1'b1;
                acc_en   = 1'b1;
                x_seen_d = x_seen_q | bus.x_done;
                y_seen_d = y_seen_q | bus.y_done;
                timer_d  = timer_q + 8'd1;
                if (x_seen_d && y_seen_d) begin
                    state_d = MAG;
                end else if (timer_d >= 8'(TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end
            end
            MAG: begin
                busy    = 1'b1;
                pix_d   = pix_val;
                state_d = OUT;
            end
            OUT: begin
                pix_valid = 1'b1;
                if (bus.pix_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            x_seen_q <= 1'b0;
            y_seen_q <= 1'b0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            x_seen_q <= x_seen_d;
            y_seen_q <= y_seen_d;
            pix_q    <= pix_d;
        end
    end

    assign bus.win_ready   = win_ready;
    assign bus.busy        = busy;
    assign bus.calc_enable = calc_enable;
    assign bus.pix_valid   = pix_valid;
    assign bus.err         = err;
    assign bus.pix_out     = pix_q;

endmodule

// File: tb/tb_sobel_conv_ctrl.sv
// tb/tb_sobel_conv_ctrl.sv - directed checks of sobel_conv_ctrl with SHIFT=2 and SHIFT=0 instances
module tb_sobel_conv_ctrl;
    import sobel_pkg::*;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sobel_conv_ctrl_if bus ();
    sobel_conv_ctrl_if bus0 ();

    sobel_conv_ctrl #(.SHIFT(2), .TIMEOUT(15), .THRESH(8'd64)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
    sobel_conv_ctrl #(.SHIFT(0), .TIMEOUT(15), .THRESH(8'd64)) dut0 (.clk(clk), .n_rst(n_rst), .bus(bus0));

    assign bus0.win_valid = bus.win_valid;
    assign bus0.x_a       = bus.x_a;
    assign bus0.x_b       = bus.x_b;
    assign bus0.x_done    = bus.x_done;
    assign bus0.y_a       = bus.y_a;
    assign bus0.y_b       = bus.y_b;
    assign bus0.y_done    = bus.y_done;
    assign bus0.pix_ready = bus.pix_ready;

`ifdef EDGE_THRESH_EN
    localparam logic [7:0] E_VERT2 = 8'h00, E_VERT0 = 8'h00, E_SAT = 8'hFF;
`else
    localparam logic [7:0] E_VERT2 = 8'd15, E_VERT0 = 8'd60, E_SAT = 8'd255;
`endif

    int gx_c[8]  = '{-1, 0, 1, -2, 2, -1, 0, 1};
    int gy_c[8]  = '{-1, -2, -1, 0, 0, 1, 2, 1};
    int tap_i[8] = '{0, 1, 2, 3, 5, 6, 7, 8};

    logic signed [4:0] xa_v[8], xb_v[8], ya_v[8], yb_v[8];
    int chk = 0, errs = 0;
    int vcyc, ecyc, ecnt, ce_cyc, ce_cnt;
    logic [7:0] pix2, pix0;

    task automatic load_win(input logic [35:0] w);
        for (int i = 0; i < 8; i++) begin
            xa_v[i] = 5'(gx_c[i]);
            ya_v[i] = 5'(gy_c[i]);
            xb_v[i] = {1'b0, w[PIX_W*tap_i[i] +: PIX_W]};
            yb_v[i] = {1'b0, w[PIX_W*tap_i[i] +: PIX_W]};
        end
    endtask

    task automatic zero_ops();
        bus.x_a = '0; bus.x_b = '0; bus.y_a = '0; bus.y_b = '0;
        bus.x_done = 1'b0; bus.y_done = 1'b0;
    endtask

    // Cycle 0 is the handshake cycle; operands are presented in cycles 2..9.
    task automatic run_window(input int xd, input int yd);
        int k;
        vcyc = -1; ecyc = -1; ecnt = 0; ce_cyc = -1; ce_cnt = 0;
        @(negedge clk);
        bus.win_valid = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                bus.win_valid = 1'b0;
            end
            k = cyc - 2;
            if (k >= 0 && k < 8) begin
                bus.x_a = xa_v[k]; bus.x_b = xb_v[k]; bus.y_a = ya_v[k]; bus.y_b = yb_v[k];
            end else begin
                bus.x_a = '0; bus.x_b = '0; bus.y_a = '0; bus.y_b = '0;
            end
            bus.x_done = (cyc == xd);
            bus.y_done = (cyc == yd);
            if (bus.calc_enable) begin ce_cnt++; if (ce_cyc < 0) ce_cyc = cyc; end
            if (bus.err) begin ecnt++; if (ecyc < 0) ecyc = cyc; end
            if (bus.pix_valid) begin
                vcyc = cyc; pix2 = bus.pix_out; pix0 = bus0.pix_out;
                break;
            end
        end
        zero_ops();
    endtask

    task automatic release_out();
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.pix_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        chk++; if (bus.win_ready !== 1'b1) begin errs++; $display("FAIL rst_win_ready got %b exp 1", bus.win_ready); end
        chk++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        chk++; if (bus.calc_enable !== 1'b0) begin errs++; $display("FAIL rst_calc_enable got %b exp 0", bus.calc_enable); end
        chk++; if (bus.pix_valid !== 1'b0) begin errs++; $display("FAIL rst_pix_valid got %b exp 0", bus.pix_valid); end
        chk++; if (bus.err !== 1'b0) begin errs++; $display("FAIL rst_err got %b exp 0", bus.err); end
        chk++; if (bus.pix_out !== 8'h00) begin errs++; $display("FAIL rst_pix_out got %0d exp 0", bus.pix_out); end
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_flat();
        load_win(36'h777777777);
        run_window(9, 9);
        chk++; if (ce_cyc !== 1) begin errs++; $display("FAIL flat_ce_cycle got %0d exp 1", ce_cyc); end
        chk++; if (ce_cnt !== 1) begin errs++; $display("FAIL flat_ce_count got %0d exp 1", ce_cnt); end
        chk++; if (vcyc !== 11) begin errs++; $display("FAIL flat_latency got %0d exp 11", vcyc); end
        chk++; if (ecnt !== 0) begin errs++; $display("FAIL flat_err got %0d exp 0", ecnt); end
        chk++; if (pix2 !== 8'h00) begin errs++; $display("FAIL flat_pix got %0d exp 0", pix2); end
        release_out();
    endtask

    task automatic test_vertical();
        load_win(36'hF80F80F80);
        run_window(9, 9);
        chk++; if (vcyc !== 11) begin errs++; $display("FAIL vert_latency got %0d exp 11", vcyc); end
        chk++; if (pix2 !== E_VERT2) begin errs++; $display("FAIL vert_pix_shift2 got %0d exp %0d", pix2, E_VERT2); end
        chk++; if (pix0 !== E_VERT0) begin errs++; $display("FAIL vert_pix_shift0 got %0d exp %0d", pix0, E_VERT0); end
        release_out();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) begin
            xa_v[i] = 5'sd12; xb_v[i] = 5'sd15; ya_v[i] = -5'sd12; yb_v[i] = 5'sd15;
        end
        run_window(9, 9);
        chk++; if (pix0 !== E_SAT) begin errs++; $display("FAIL sat_shift0 got %0d exp %0d", pix0, E_SAT); end
        chk++; if (pix2 !== E_SAT) begin errs++; $display("FAIL sat_shift2 got %0d exp %0d", pix2, E_SAT); end
        release_out();
    endtask

    task automatic test_late_done();
        @(negedge clk);
        bus.x_done = 1'b1; bus.y_done = 1'b1;
        @(negedge clk);
        bus.x_done = 1'b0; bus.y_done = 1'b0;
        chk++; if (bus.win_ready !== 1'b1 || bus.busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
            errs++; $display("FAIL idle_done_ignored got ready=%b busy=%b valid=%b exp 1 0 0", bus.win_ready, bus.busy, bus.pix_valid);
        end
        load_win(36'hF80F80F80);
        run_window(9, 12);
        chk++; if (vcyc !== 14) begin errs++; $display("FAIL late_latency got %0d exp 14", vcyc); end
        chk++; if (pix2 !== E_VERT2) begin errs++; $display("FAIL late_pix got %0d exp %0d", pix2, E_VERT2); end
        release_out();
    endtask

    task automatic test_timeout();
        load_win(36'hF80F80F80);
        run_window(9, -1);
        chk++; if (ecnt !== 1) begin errs++; $display("FAIL to_err_count got %0d exp 1", ecnt); end
        chk++; if (ecyc !== 16) begin errs++; $display("FAIL to_err_cycle got %0d exp 16", ecyc); end
        chk++; if (vcyc !== -1) begin errs++; $display("FAIL to_pix_valid got %0d exp -1", vcyc); end
        chk++; if (bus.win_ready !== 1'b1) begin errs++; $display("FAIL to_idle got %b exp 1", bus.win_ready); end
        run_window(9, 9);
        chk++; if (vcyc !== 11) begin errs++; $display("FAIL to_next_latency got %0d exp 11", vcyc); end
        chk++; if (pix2 !== E_VERT2) begin errs++; $display("FAIL to_next_pix got %0d exp %0d", pix2, E_VERT2); end
        release_out();
    endtask

    task automatic test_backpressure();
        load_win(36'hF80F80F80);
        run_window(9, 9);
        for (int i = 0; i < 5; i++) begin
            bus.win_valid = 1'b1;
            chk++; if (bus.pix_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.pix_valid); end
            chk++; if (bus.pix_out !== E_VERT2) begin errs++; $display("FAIL bp_pix[%0d] got %0d exp %0d", i, bus.pix_out, E_VERT2); end
            chk++; if (bus.win_ready !== 1'b0) begin errs++; $display("FAIL bp_win_ready[%0d] got %b exp 0", i, bus.win_ready); end
            @(negedge clk);
        end
        bus.win_valid = 1'b0;
        bus.pix_ready = 1'b1;
        @(negedge clk);
        bus.pix_ready = 1'b0;
        chk++; if (bus.pix_valid !== 1'b0 || bus.win_ready !== 1'b1) begin
            errs++; $display("FAIL bp_release got valid=%b ready=%b exp 0 1", bus.pix_valid, bus.win_ready);
        end
    endtask

    task automatic test_reset_mid();
        load_win(36'hF80F80F80);
        @(negedge clk); bus.win_valid = 1'b1;
        @(negedge clk); bus.win_valid = 1'b0;
        @(negedge clk); bus.x_a = xa_v[0]; bus.x_b = 5'sd15; bus.y_a = ya_v[0]; bus.y_b = 5'sd15;
        @(negedge clk);
        chk++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b exp 1", bus.busy); end
        n_rst = 1'b0;
        #1;
        chk++; if (bus.win_ready !== 1'b1 || bus.busy !== 1'b0 || bus.calc_enable !== 1'b0) begin
            errs++; $display("FAIL mid_rst_ctrl got ready=%b busy=%b ce=%b exp 1 0 0", bus.win_ready, bus.busy, bus.calc_enable);
        end
        chk++; if (bus.pix_valid !== 1'b0 || bus.err !== 1'b0 || bus.pix_out !== 8'h00) begin
            errs++; $display("FAIL mid_rst_out got valid=%b err=%b pix=%0d exp 0 0 0", bus.pix_valid, bus.err, bus.pix_out);
        end
        zero_ops();
        @(negedge clk);
        n_rst = 1'b1;
        run_window(9, 9);
        chk++; if (vcyc !== 11) begin errs++; $display("FAIL mid_next_latency got %0d exp 11", vcyc); end
        chk++; if (pix0 !== E_VERT0) begin errs++; $display("FAIL mid_next_pix got %0d exp %0d", pix0, E_VERT0); end
        release_out();
    endtask

    initial begin
        bus.win_valid = 1'b0;
        bus.pix_ready = 1'b0;
        zero_ops();
        test_reset();
        test_flat();
        test_vertical();
        test_saturate();
        test_late_done();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
